// File: rtl/pipe_pkg.sv
// Shared sizing helpers and parameter-legality constants for the pipelined
// output FIFO family.
package pipe_pkg;

  // Smallest legal storage depth.
  localparam int unsigned PIPE_MIN_DEPTH = 2;
  // Smallest legal word width.
  localparam int unsigned PIPE_MIN_BITS  = 1;

  // Kind of pointer/count update applied on a clock edge.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Pointer width: indexes DEPTH entries.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Count width: must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n >= PIPE_MIN_DEPTH) && ((n & (n - 1)) == 0);
  endfunction

  // DEPTH must be a power of two and SLACK must leave room below it.
  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned slack);
    return is_pow2(depth) && (slack < depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count and push/pop arbitration for
// pipe_out_fifo. A push into a full FIFO is accepted only when a pop frees
// a slot in the same cycle; otherwise it is refused.
module fifo_ptr_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push_req,
  input  logic                        i_pop_req,
  output logic                        o_wr_en,
  output logic [ptr_w(DEPTH)-1:0]     o_wr_ptr,
  output logic [ptr_w(DEPTH)-1:0]     o_rd_ptr,
  output logic [cnt_w(DEPTH)-1:0]     o_count
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned AW = ptr_w(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  fifo_op_e      w_op;

  // Arbitrate this cycle's push/pop from the registered count.
  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
    w_pop   = i_pop_req && !w_empty;
    w_push  = i_push_req && (!w_full || w_pop);
    w_op    = fifo_op_e'({w_push, w_pop});
  end

  // Advance pointers (wrapping modulo DEPTH) and track occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_count  <= r_count + 1'b1;
        end
        OP_POP: begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_count  <= r_count - 1'b1;
        end
        OP_BOTH: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_wr_en  = w_push;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule

// File: rtl/pipe_out_fifo.sv
// Output FIFO behind a fixed-latency upstream delay pipeline.
// o_en_up throttles the upstream stage early enough that the SLACK words
// already in flight always fit. First-word fall-through read port with
// one cycle write-to-read latency.
// Optional macro PIPE_OUT_FIFO_OVF_EN adds a sticky overflow flag o_ovf.
module pipe_out_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 1,
  parameter int unsigned SLACK = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [BITS-1:0]         i_d,
  output logic                    o_en_up,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [BITS-1:0]         o_q,
  output logic [cnt_w(DEPTH)-1:0] o_count
`ifdef PIPE_OUT_FIFO_OVF_EN
  , output logic                  o_ovf
`endif
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned AW = ptr_w(DEPTH);
  localparam logic [CW-1:0] EN_LIMIT = CW'(DEPTH - SLACK);

  if (!params_legal(DEPTH, SLACK) || (BITS < PIPE_MIN_BITS)) begin : g_bad_params
    $error("pipe_out_fifo: DEPTH must be a power of two >= 2, SLACK < DEPTH, BITS >= 1");
  end

  logic [BITS-1:0] r_mem [DEPTH];
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_ptr;
  logic [AW-1:0]   w_rd_ptr;
  logic [CW-1:0]   w_count;
  logic            w_pop_req;

  assign w_pop_req = o_valid && i_ready;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push_req (i_valid),
    .i_pop_req  (w_pop_req),
    .o_wr_en    (w_wr_en),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (w_count)
  );

  // Storage array; unreset, the read side is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_ptr] <= i_d;
    end
  end

  // Read port and upstream throttle, all from registered state only.
  always_comb begin
    o_valid = (w_count != '0);
    o_q     = o_valid ? r_mem[w_rd_ptr] : '0;
    o_en_up = (w_count < EN_LIMIT);
  end

  assign o_count = w_count;

`ifdef PIPE_OUT_FIFO_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = i_valid && (w_count == CW'(DEPTH)) && !w_pop_req;

  // Sticky overflow: set after any refused push, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Scoreboard bench for pipe_out_fifo (DEPTH=8, SLACK=4, BITS=8).
module tb_pipe_out_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned BITS  = 8;
  localparam int unsigned SLACK = 4;

  logic            i_clk;
  logic            i_rst;
  logic            i_valid;
  logic [BITS-1:0] i_d;
  logic            o_en_up;
  logic            o_valid;
  logic            i_ready;
  logic [BITS-1:0] o_q;
  logic [3:0]      o_count;
`ifdef PIPE_OUT_FIFO_OVF_EN
  logic            o_ovf;
`endif

  int unsigned     n_checks;
  int unsigned     n_errors;
  logic [BITS-1:0] sb_q [$];
  logic            ovf_exp;

  pipe_out_fifo #(
    .DEPTH (DEPTH),
    .BITS  (BITS),
    .SLACK (SLACK)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_d     (i_d),
    .o_en_up (o_en_up),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_q     (o_q),
    .o_count (o_count)
`ifdef PIPE_OUT_FIFO_OVF_EN
    , .o_ovf (o_ovf)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every visible output against the scoreboard's occupancy.
  task automatic check_state();
    int unsigned sz;
    sz = sb_q.size();
    check_eq("count", 32'(o_count), sz);
    check_eq("valid", 32'(o_valid), 32'(sz != 0));
    check_eq("en_up", 32'(o_en_up), 32'(sz < DEPTH - SLACK));
    if (sz == 0) check_eq("q_masked", 32'(o_q), 32'd0);
    else         check_eq("q_head", 32'(o_q), 32'(sb_q[0]));
`ifdef PIPE_OUT_FIFO_OVF_EN
    check_eq("ovf", 32'(o_ovf), 32'(ovf_exp));
`endif
  endtask

  // Called at a falling edge: check, drive one cycle, update scoreboard.
  task automatic cycle(input logic v, input logic [BITS-1:0] d, input logic rdy);
    int unsigned sz;
    logic        pop;
    logic [BITS-1:0] exp_w;
    check_state();
    i_valid = v;
    i_d     = d;
    i_ready = rdy;
    sz  = sb_q.size();
    pop = rdy && (sz != 0);
    if (pop) begin
      exp_w = sb_q.pop_front();
      check_eq("pop_data", 32'(o_q), 32'(exp_w));
    end
    if (v) begin
      if ((sz < DEPTH) || pop) sb_q.push_back(d);
      else                     ovf_exp = 1'b1;
    end
    @(negedge i_clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ovf_exp  = 1'b0;
    i_rst    = 1'b0;
    i_valid  = 1'b0;
    i_d      = '0;
    i_ready  = 1'b0;
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    check_state();
    i_rst = 1'b0;

    // Push 1,0,1 with downstream always ready, then drain/idle.
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // Stall downstream: four pushes drop o_en_up, four in-flight fill to 8.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    check_state();

    // Full with simultaneous push and pop for ten cycles.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b1);

    // Full push without pop: word refused, overflow sticky.
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Drain to five words, then reset asynchronously between edges.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    check_state();
    i_valid = 1'b0;
    i_ready = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    sb_q.delete();
    ovf_exp = 1'b0;
    check_eq("arst_valid", 32'(o_valid), 32'd0);
    check_eq("arst_count", 32'(o_count), 32'd0);
    check_eq("arst_en_up", 32'(o_en_up), 32'd1);
    check_eq("arst_q", 32'(o_q), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Random traffic across several pointer wraps, then drain.
    for (int i = 0; i < 6 * DEPTH; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1);
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
